control_sequencer: RTL

- Hardwired Moore control unit that generates every datapath control strobe for phase-1 register-register instructions.
- It drives the CPU datapath control inputs that the phase-1 benches previously drove by hand, i.e. the producer side of the datapath control interface.
- Sequence: fetch T0–T2, then execute T3–T6, with a memory-ready handshake during instruction read.

---
 rtl/control_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, execute T3-T6 for register-register instructions.
// Optional ILLEGAL_TRAP_EN: undefined opcodes halt the sequencer and raise the sticky `illegal`.
module control_sequencer #(
    parameter int unsigned NREG = 16,
    parameter int unsigned OPW  = 5
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [31:0]     ir,
    input  logic            mem_ready,
    output logic            PCout,
    output logic            IncPC,
    output logic            MARin,
    output logic            memRead,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            Zhighout,
    output logic            Zlowout,
    output logic            HIin,
    output logic            LOin,
    output logic [NREG-1:0] reg_out,
    output logic [NREG-1:0] reg_in,
    output logic [OPW-1:0]  alu_op,
    output logic            run
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic            illegal
`endif
);

    typedef enum logic [3:0] {
        StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalted
    } state_e;

    typedef enum logic [2:0] {
        ClsBin, ClsMulDiv, ClsUnary, ClsNop, ClsHalt, ClsIll
    } cls_e;

    state_e          state_q, state_d;
    cls_e            cls;
    logic [OPW-1:0]  op;
    logic [3:0]      ra, rb, rc;

    assign op = ir[31:32-OPW];
    assign ra = ir[26:23];
    assign rb = ir[22:19];
    assign rc = ir[18:15];

    function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
        return NREG'(1) << idx;
    endfunction

    always_comb begin
        cls = ClsIll;
        if (op >= OPW'(3) && op <= OPW'(11)) begin
            cls = ClsBin;
        end else if (op == OPW'(15) || op == OPW'(16)) begin
            cls = ClsMulDiv;
        end else if (op == OPW'(17) || op == OPW'(18)) begin
            cls = ClsUnary;
        end else if (op == OPW'(26)) begin
            cls = ClsNop;
        end else if (op == OPW'(27)) begin
            cls = ClsHalt;
        end
    end

    // Reset forces StIdle asynchronously, so every strobe drops with clear.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        PCout    = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        memRead  = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        reg_out  = '0;
        reg_in   = '0;
        alu_op   = '0;
        run      = (state_q != StIdle) && (state_q != StHalted);

        unique case (state_q)
            StIdle: state_d = StT0;
            StT0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                state_d = StT1;
            end
            StT1: begin
                memRead = 1'b1;
                MDRin   = 1'b1;
                state_d = mem_ready ? StT2 : StT1;
            end
            StT2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = StT3;
            end
            StT3: begin
                state_d = StT0;
                unique case (cls)
                    ClsBin: begin
                        reg_out = onehot(rb);
                        Yin     = 1'b1;
                        state_d = StT4;
                    end
                    ClsMulDiv: begin
                        reg_out = onehot(ra);
                        Yin     = 1'b1;
                        state_d = StT4;
                    end
                    ClsUnary: begin
                        reg_out = onehot(rb);
                        Zin     = 1'b1;
                        alu_op  = op;
                        state_d = StT4;
                    end
                    ClsHalt: state_d = StHalted;
                    ClsNop:  state_d = StT0;
                    ClsIll: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = StHalted;
`else
                        state_d = StT0;
`endif
                    end
                    default: state_d = StT0;
                endcase
            end
            StT4: begin
                if (cls == ClsUnary) begin
                    Zlowout = 1'b1;
                    reg_in  = onehot(ra);
                    state_d = StT0;
                end else begin
                    reg_out = (cls == ClsMulDiv) ? onehot(rb) : onehot(rc);
                    Zin     = 1'b1;
                    alu_op  = op;
                    state_d = StT5;
                end
            end
            StT5: begin
                Zlowout = 1'b1;
                if (cls == ClsMulDiv) begin
                    LOin    = 1'b1;
                    state_d = StT6;
                end else begin
                    reg_in  = onehot(ra);
                    state_d = StT0;
                end
            end
            StT6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                state_d  = StT0;
            end
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    assign illegal_d = illegal_q | ((state_q == StT3) && (cls == ClsIll));

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`endif

endmodule
